// File: rtl/irq_pkg.sv
// irq_pkg: shared state encoding, default sizing and priority encoder for irq_ctrl
package irq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, HOLDOFF = 2'd2} state_t;
  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLDOFF = 3;
  function automatic logic [4:0] prio_enc(input logic [31:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 31; i >= 0; i--) r = v[i] ? 5'(i) : r;
    return r;
  endfunction
endpackage

// File: rtl/irq_sync.sv
// irq_sync: multi-flop synchroniser with a one-cycle rising-edge strobe
module irq_sync import irq_pkg::*; #(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [STAGES:0] sh;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sh <= '0;
    else sh <= {sh[STAGES-1:0], d};
  assign q = sh[STAGES-1];
  assign rise = q & ~sh[STAGES];
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: multi-source maskable interrupt controller with fixed priority and post-ack holdoff
module irq_ctrl import irq_pkg::*; #(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLDOFF = DEF_HOLDOFF,
  parameter int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               ack,
  output logic               interrupter,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending
);
  localparam int CW = $clog2(HOLDOFF + 1);
  logic [NUM_SRC-1:0] s_sync, rise, pend_q, clr, req;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic int_n;
  logic [ID_W-1:0] id_n;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(src[g]), .q(s_sync[g]), .rise(rise[g]));
  end
  assign clr = (state == ASSERT && ack) ? (NUM_SRC'(1) << irq_id) : '0;
  assign pending = (edge_mode & pend_q) | (~edge_mode & s_sync);
  assign req = pending & mask;
  // The last holdoff cycle arbitrates like IDLE so the low gap is exactly HOLDOFF cycles.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    int_n = interrupter;
    id_n = irq_id;
    if (state == ASSERT) begin
      if (ack) begin
        state_n = irq_pkg::HOLDOFF;
        cnt_n = CW'(HOLDOFF);
        int_n = 1'b0;
      end
    end else if (state == irq_pkg::HOLDOFF && cnt != CW'(1)) begin
      cnt_n = cnt - 1'b1;
    end else if (req != '0) begin
      state_n = ASSERT;
      int_n = 1'b1;
      id_n = ID_W'(prio_enc(32'(req)));
    end else begin
      state_n = IDLE;
    end
  end
  // Set beats clear: a fresh edge during the acking cycle stays latched.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      interrupter <= 1'b0;
      irq_id <= '0;
      pend_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      interrupter <= int_n;
      irq_id <= id_n;
      pend_q <= edge_mode & (rise | (pend_q & ~clr));
    end
endmodule
